pipeline_credit_fifo: RTL and testbench

- Output buffer that sits directly downstream of the fixed-latency, non-stallable `pipeline` delay line.
- The delay line cannot stall, so this block holds its results whenever the consumer applies backpressure.
- It issues credits to the launch point upstream of the delay line. Entries still in flight plus entries already buffered can never exceed the buffer depth.
- Data can therefore never be lost at the pipeline output.

---
 rtl/pipeline_credit_fifo.sv | 134 +++++++++++++
 tb/tb_pipeline_credit_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_credit_fifo.sv
// Credit-managed output buffer behind a fixed-latency, non-stallable delay line.
// Credits guarantee that buffered plus in-flight items never exceed DEPTH.
module pipeline_credit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  issue_valid_in,
  output logic                  issue_ready_out,
  input  logic                  result_valid_in,
  input  logic [DATA_WIDTH-1:0] result_data_in,
  output logic                  m_valid_out,
  output logic [DATA_WIDTH-1:0] m_data_out,
  input  logic                  m_ready_in,
  output logic [CNT_WIDTH-1:0]  occupancy_out,
  output logic [CNT_WIDTH-1:0]  inflight_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH:0]   DEPTH_W  = (CNT_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_WIDTH-1:0] occ_q, occ_d;
  logic [CNT_WIDTH-1:0] infl_q, infl_d;
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic [CNT_WIDTH:0] credit_sum_s;
  logic               launch_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_ok_s;

  assign credit_sum_s    = {1'b0, occ_q} + {1'b0, infl_q};
  assign issue_ready_out = rst_in && (credit_sum_s < DEPTH_W);
  assign launch_s        = issue_valid_in && issue_ready_out;
  assign full_s          = (occ_q == DEPTH_C);
  // A full buffer drops the word even when a pop frees a slot in the same cycle.
  assign wr_ok_s         = result_valid_in && !full_s;
  assign m_valid_out     = (occ_q != {CNT_WIDTH{1'b0}});
  assign pop_s           = m_valid_out && m_ready_in;
  assign m_data_out      = mem_q[rptr_q];
  assign occupancy_out   = occ_q;
  assign inflight_out    = infl_q;
  assign overflow_out    = ovf_q;
  assign underflow_out   = unf_q;

  always_comb begin
    infl_d = infl_q;
    unf_d  = unf_q;
    if (launch_s && !result_valid_in) begin
      if (infl_q != DEPTH_C) begin
        infl_d = infl_q + CNT_WIDTH'(1);
      end else begin
        infl_d = infl_q;
      end
    end else if (!launch_s && result_valid_in) begin
      if (infl_q == {CNT_WIDTH{1'b0}}) begin
        infl_d = {CNT_WIDTH{1'b0}};
        unf_d  = 1'b1;
      end else begin
        infl_d = infl_q - CNT_WIDTH'(1);
      end
    end else begin
      infl_d = infl_q;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({wr_ok_s, pop_s})
      2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (wr_ok_s) begin
      wptr_d = (wptr_q == LAST_PTR) ? {PTR_WIDTH{1'b0}} : wptr_q + PTR_WIDTH'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == LAST_PTR) ? {PTR_WIDTH{1'b0}} : rptr_q + PTR_WIDTH'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (result_valid_in && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      occ_q  <= {CNT_WIDTH{1'b0}};
      infl_q <= {CNT_WIDTH{1'b0}};
      wptr_q <= {PTR_WIDTH{1'b0}};
      rptr_q <= {PTR_WIDTH{1'b0}};
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk_in) begin
    if (wr_ok_s && rst_in) begin
      mem_q[wptr_q] <= result_data_in;
    end
  end

endmodule

// File: tb/tb_pipeline_credit_fifo.sv
// Bench: directed checks on a DEPTH=4 instance and randomized checks against a
// queue-based reference model on a DEPTH=3 instance.
module tb_pipeline_credit_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        a_iv, a_ir, a_rv, a_mv, a_mr, a_ov, a_un;
  logic [31:0] a_rd, a_md;
  logic [2:0]  a_occ, a_inf;
  // DEPTH=3 instance
  logic        b_iv, b_ir, b_rv, b_mv, b_mr, b_ov, b_un;
  logic [31:0] b_rd, b_md;
  logic [1:0]  b_occ, b_inf;

  pipeline_credit_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut_a (
    .clk_in(clk), .rst_in(rst_n),
    .issue_valid_in(a_iv), .issue_ready_out(a_ir),
    .result_valid_in(a_rv), .result_data_in(a_rd),
    .m_valid_out(a_mv), .m_data_out(a_md), .m_ready_in(a_mr),
    .occupancy_out(a_occ), .inflight_out(a_inf),
    .overflow_out(a_ov), .underflow_out(a_un)
  );

  pipeline_credit_fifo #(.DATA_WIDTH(32), .DEPTH(3)) dut_b (
    .clk_in(clk), .rst_in(rst_n),
    .issue_valid_in(b_iv), .issue_ready_out(b_ir),
    .result_valid_in(b_rv), .result_data_in(b_rd),
    .m_valid_out(b_mv), .m_data_out(b_md), .m_ready_in(b_mr),
    .occupancy_out(b_occ), .inflight_out(b_inf),
    .overflow_out(b_ov), .underflow_out(b_un)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for the DEPTH=3 instance: plain queues.
  logic [31:0] buf_q[$];
  logic [31:0] pipe_data[$];
  int          pipe_due[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          seq      = 0;
  int          consumed = 0;

  // mode 0: words 1..10, ready toggling; mode 1: random; mode 2: drain
  task automatic run_b(input int mode, input int ncyc);
    logic        exp_rdy, launch, pop;
    logic [31:0] d;
    int          lat, due;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      exp_rdy = (buf_q.size() + pipe_data.size()) < 3;
      check_eq("b_ready", 64'(b_ir), 64'(exp_rdy));
      check_eq("b_mvalid", 64'(b_mv), 64'(buf_q.size() != 0));
      if (buf_q.size() != 0) check_eq("b_mdata", 64'(b_md), 64'(buf_q[0]));
      check_eq("b_occ", 64'(b_occ), 64'(buf_q.size()));
      check_eq("b_inflight", 64'(b_inf), 64'(pipe_data.size()));
      check_eq("b_flags", 64'({b_ov, b_un}), 64'd0);

      case (mode)
        0:       begin b_iv = (seq < 10); b_mr = (i % 2 == 0); end
        1:       begin b_iv = ($urandom_range(0, 3) != 0); b_mr = $urandom_range(0, 1) == 1; end
        default: begin b_iv = 1'b0; b_mr = 1'b1; end
      endcase

      if (pipe_due.size() != 0 && pipe_due[0] <= cyc) begin
        b_rv = 1'b1;
        b_rd = pipe_data.pop_front();
        void'(pipe_due.pop_front());
      end else begin
        b_rv = 1'b0;
        b_rd = $urandom;
      end

      pop = b_mr && (buf_q.size() != 0);
      if (pop) begin
        if (mode == 0) check_eq("b_wrap_order", 64'(b_md), 64'(consumed + 1));
        consumed++;
        void'(buf_q.pop_front());
      end
      if (b_rv) buf_q.push_back(b_rd);

      launch = b_iv && exp_rdy;
      if (launch) begin
        if (mode == 0) begin seq++; d = 32'(seq); lat = 2; end
        else begin d = $urandom; lat = $urandom_range(1, 5); end
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pipe_data.push_back(d);
        pipe_due.push_back(due);
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  initial begin
    logic [2:0] sr;
    logic       launch;
    int         nres, nlaunch;

    rst_n = 1'b0;
    a_iv = 1'b1; a_rv = 1'b0; a_rd = 32'd0; a_mr = 1'b0;
    b_iv = 1'b1; b_rv = 1'b0; b_rd = 32'd0; b_mr = 1'b0;

    // Reset behaviour
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ready_a", 64'(a_ir), 64'd0);
      check_eq("rst_ready_b", 64'(b_ir), 64'd0);
    end
    check_eq("rst_mvalid", 64'({a_mv, b_mv}), 64'd0);
    check_eq("rst_occ", 64'({a_occ, b_occ}), 64'd0);
    check_eq("rst_inflight", 64'({a_inf, b_inf}), 64'd0);
    check_eq("rst_flags", 64'({a_ov, a_un, b_ov, b_un}), 64'd0);
    b_iv = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("release_ready", 64'(a_ir), 64'd1);

    // Credit exhaustion on DEPTH=4 with a 3-stage delay line
    sr = 3'b000; nres = 0; nlaunch = 0;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      check_eq("exh_ready", 64'(a_ir), 64'(c < 4));
      launch = a_iv && a_ir;
      if (launch) nlaunch++;
      a_rv = sr[2];
      a_rd = sr[2] ? 32'hA0 + 32'(nres) : 32'd0;
      if (sr[2]) nres++;
      sr = {sr[1:0], launch};
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("exh_launches", 64'(nlaunch), 64'd4);
    check_eq("exh_occ", 64'(a_occ), 64'd4);
    check_eq("exh_inflight", 64'(a_inf), 64'd0);
    check_eq("exh_overflow", 64'(a_ov), 64'd0);
    check_eq("exh_ready_full", 64'(a_ir), 64'd0);
    check_eq("exh_head", 64'(a_md), 64'hA0);

    // Drain one and observe the credit return one cycle later
    a_iv = 1'b0; a_rv = 1'b0; a_mr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("drain_ready", 64'(a_ir), 64'd1);
    check_eq("drain_head", 64'(a_md), 64'hA1);
    check_eq("drain_occ", 64'(a_occ), 64'd3);

    // Reach occupancy 2 / inflight 1, then launch + result + pop together
    a_iv = 1'b1; a_mr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("sim_pre_occ", 64'(a_occ), 64'd2);
    check_eq("sim_pre_inf", 64'(a_inf), 64'd1);
    check_eq("sim_pre_head", 64'(a_md), 64'hA2);
    a_iv = 1'b1; a_rv = 1'b1; a_rd = 32'hB0; a_mr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("sim_occ", 64'(a_occ), 64'd2);
    check_eq("sim_inf", 64'(a_inf), 64'd1);
    check_eq("sim_head", 64'(a_md), 64'hA3);
    a_iv = 1'b0; a_rv = 1'b0; a_mr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("sim_order", 64'(a_md), 64'hB0);
    check_eq("sim_occ2", 64'(a_occ), 64'd1);
    a_mr = 1'b0;

    // DEPTH=3: wrap-around stream, random traffic, drain
    run_b(0, 60);
    check_eq("wrap_consumed", 64'(consumed), 64'd10);
    run_b(1, 500);
    run_b(2, 30);

    // Error flags on DEPTH=3
    @(negedge clk);
    b_iv = 1'b0; b_mr = 1'b0; b_rv = 1'b1; b_rd = 32'h11;
    @(posedge clk); @(negedge clk);
    check_eq("unf_flag", 64'(b_un), 64'd1);
    check_eq("unf_inflight", 64'(b_inf), 64'd0);
    check_eq("unf_occ", 64'(b_occ), 64'd1);
    b_rd = 32'h22;
    @(posedge clk); @(negedge clk);
    b_rd = 32'h33;
    @(posedge clk); @(negedge clk);
    check_eq("ovf_pre_occ", 64'(b_occ), 64'd3);
    check_eq("ovf_pre_flag", 64'(b_ov), 64'd0);
    check_eq("ovf_pre_head", 64'(b_md), 64'h11);
    b_rd = 32'h44; b_mr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("ovf_flag", 64'(b_ov), 64'd1);
    check_eq("ovf_occ", 64'(b_occ), 64'd2);
    check_eq("ovf_head", 64'(b_md), 64'h22);
    b_rv = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("ovf_next", 64'(b_md), 64'h33);
    @(posedge clk); @(negedge clk);
    check_eq("ovf_empty", 64'(b_mv), 64'd0);
    check_eq("flags_sticky", 64'({b_ov, b_un}), 64'h3);
    b_mr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
